video_timing: RTL and testbench
===============================

// Module: video_timing
// PURPOSE
//  Raster timing generator for the ST shifter. It consumes the 122-bit mode_str produced by the
//  video mode multiplexer and runs the horizontal and vertical pixel/line counters from it.
//  It produces sync, display-enable, border and blank qualifiers, plus line/frame strobes, for
//  the shifter pixel pipeline and the scan doubler.
//  mode_str is shadowed and is only taken up at a frame boundary, so mono/pal/pal56 changes
//  never produce a torn frame.
// PARAMETERS
//  PIPE   0  extra register stages (0..3) applied equally to hs/vs/de/border/blank/strobes;
//            counters are never delayed.
// PORTS
//  clk          in   1    system clock
//  reset_n      in   1    synchronous reset, active low
//  pix_en       in   1    pixel clock enable; all state advances only when high
//  mode_str     in   122  {h_sp,h_act,h_rb,h_fp,h_sy,h_bp,h_tot, v_sp,v_act,v_rb,v_fp,v_sy,v_bp,v_tot}
//                         (10-bit end positions, each "last index of region"; h at [121:61], v at [60:0])
//  h_cnt        out  10   pixel counter, 0..h_tot
//  v_cnt        out  10   line counter, 0..v_tot
//  hs, vs       out  1    sync; level = sp inside sync region, ~sp outside
//  de           out  1    active picture (640x400 area)
//  border       out  1    border area (not de, not blank)
//  blank        out  1    h or v porch/sync region
//  line_start   out  1    1-cycle pulse when h_cnt becomes 0
//  frame_start  out  1    1-cycle pulse when h_cnt and v_cnt both become 0
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): h_cnt=v_cnt=0; shadow<=mode_str; de=border=blank=0;
//    line_start=frame_start=0; hs=~mode_str[121]; vs=~mode_str[60]. Pipe stages clear to the
//    same values. Reset mid-frame abandons the frame immediately.
//  - pix_en=0: every register holds, and strobes are 0 on those cycles.
//  - Horizontal: h_cnt==h_tot -> 0, else +1.
//  - Vertical: v_cnt advances only when h_cnt wraps; v_cnt==v_tot -> 0, else +1.
//  - Shadow load: the shadow reloads from mode_str in the same enabled cycle that (h,v) wraps to
//    (0,0). The new timing applies from h_cnt=0 of that frame. Mid-frame mode_str changes are
//    ignored until then.
//  - Region decode (c = counter, using shadow fields; identical form for h and v):
//    - de_x     : c<=act
//    - border_x : act<c<=rb  or  bp<c<=tot
//    - blank_x  : rb<c<=bp
//    - sync_x   : fp<c<=sy
//  - Output combination: de = de_h&de_v; blank = blank_h|blank_v; border = ~de&~blank.
//  - Zero-width regions (e.g. rb==act) never assert.
//  - Timing: flags are registered from next-state counter values. With PIPE=0, every flag
//    describes the h_cnt/v_cnt shown in the same cycle (zero latency). Each PIPE stage adds one
//    enabled cycle to the flags and strobes.
//  - vs and v-regions change only at h_cnt==0.
//  - Field ordering: the producer guarantees act<=rb<=fp<=sy<=bp<=tot. No check is performed.
//    Because shadowing happens at (0,0), counters never exceed tot.
//  - pix_en must be high for the cycle in which reset_n deasserts. The first enabled cycle then
//    shows h_cnt=0, v_cnt=0, de=1, frame_start=1, line_start=1.
// TESTING
//  1. pal50 mode (h ends 639/679/759/799/951/991; v ends 399/479/516/519/555/635), pix_en=1
//     -> hs high for h_cnt 760..799 (40 clk); line period 992 clk; vs high on lines 517..519;
//     frame_start every 992*636 clk.
//  2. mono mode (h 639/639/663/703/831/831; v 399/399/454/457/531/531)
//     -> border never 1; hs low for h_cnt 664..703; de 640 clk per line on lines 0..399.
//  3. Switch mode_str pal50->ntsc at v_cnt=200
//     -> pal50 timing continues until v_cnt=635/h_cnt=991; next frame uses ntsc totals.
//  4. pix_en toggling 1,0,1,0 -> h_cnt steps once per enabled cycle; line_start is a single clk
//     wide; outputs hold while pix_en=0.
//  5. reset_n low for 1 clk at h_cnt=500, v_cnt=300 -> next clk h=v=0, de=0, hs/vs inactive.
//     After release: frame_start=1, de=1.
//  6. PIPE=2, pal50 -> hs rises 2 enabled cycles after h_cnt=760; h_cnt unaffected.

Source files
------------

// File: rtl/video_timing_if.sv
// Raster timing bundle: mode descriptor and pixel enable in, counters and qualifiers out.
interface video_timing_if;
  logic         pix_en;
  logic [121:0] mode_str;
  logic [9:0]   h_cnt;
  logic [9:0]   v_cnt;
  logic         hs;
  logic         vs;
  logic         de;
  logic         border;
  logic         blank;
  logic         line_start;
  logic         frame_start;

  // No valid/ready pair: pix_en is a qualifier. Every output is a registered value that
  // describes the last clk edge at which pix_en was high, and strobes read 0 after an edge
  // at which pix_en was low.
  modport master (
    output pix_en, mode_str,
    input  h_cnt, v_cnt, hs, vs, de, border, blank, line_start, frame_start
  );

  modport slave (
    input  pix_en, mode_str,
    output h_cnt, v_cnt, hs, vs, de, border, blank, line_start, frame_start
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters driven by a frame-shadowed mode descriptor,
// with region flags decoded from next-state counters so they line up with the counters.
module video_timing #(
  parameter int PIPE = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  video_timing_if.slave vif
);

  typedef struct packed {
    logic       sp;
    logic [9:0] act;
    logic [9:0] rb;
    logic [9:0] fp;
    logic [9:0] sy;
    logic [9:0] bp;
  } region_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic border;
    logic blank;
    logic line_start;
    logic frame_start;
  } flags_t;

  logic [121:0] shadow;
  logic         started;
  logic         en_q;
  logic [9:0]   h_cnt, v_cnt, nxt_h, nxt_v;
  logic         h_wrap, v_wrap, frame_wrap;
  region_t      cm_h, cm_v;
  logic [2:0]   reg_h, reg_v;
  flags_t       nxt_flags, rst_flags;
  flags_t       stg [PIPE+1];

  // {de, blank, sync} membership of one counter against one axis
  function automatic logic [2:0] region(region_t a, logic [9:0] c);
    region = {c <= a.act, (c > a.rb) && (c <= a.bp), (c > a.fp) && (c <= a.sy)};
  endfunction

  always_comb begin
    h_wrap     = (h_cnt == shadow[70:61]);
    v_wrap     = (v_cnt == shadow[9:0]);
    frame_wrap = started && h_wrap && v_wrap;

    // The first enabled cycle after reset presents (0,0) instead of advancing
    nxt_h = (!started || h_wrap) ? 10'd0 : h_cnt + 10'd1;
    nxt_v = v_cnt;
    if (!started || (h_wrap && v_wrap)) nxt_v = 10'd0;
    else if (h_wrap)                    nxt_v = v_cnt + 10'd1;

    // A new mode takes effect on the very cycle that shows the new frame's (0,0)
    cm_h = frame_wrap ? region_t'(vif.mode_str[121:71]) : region_t'(shadow[121:71]);
    cm_v = frame_wrap ? region_t'(vif.mode_str[60:10])  : region_t'(shadow[60:10]);

    reg_h = region(cm_h, nxt_h);
    reg_v = region(cm_v, nxt_v);

    nxt_flags             = '0;
    nxt_flags.hs          = reg_h[0] ? cm_h.sp : ~cm_h.sp;
    nxt_flags.vs          = reg_v[0] ? cm_v.sp : ~cm_v.sp;
    nxt_flags.de          = reg_h[2] & reg_v[2];
    nxt_flags.blank       = reg_h[1] | reg_v[1];
    nxt_flags.border      = ~(reg_h[2] & reg_v[2]) & ~(reg_h[1] | reg_v[1]);
    nxt_flags.line_start  = (nxt_h == 10'd0);
    nxt_flags.frame_start = (nxt_h == 10'd0) && (nxt_v == 10'd0);

    rst_flags    = '0;
    rst_flags.hs = ~vif.mode_str[121];
    rst_flags.vs = ~vif.mode_str[60];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      shadow  <= vif.mode_str;
      started <= 1'b0;
      en_q    <= 1'b0;
      for (int k = 0; k <= PIPE; k++) stg[k] <= rst_flags;
    end else begin
      en_q <= vif.pix_en;
      if (vif.pix_en) begin
        h_cnt   <= nxt_h;
        v_cnt   <= nxt_v;
        started <= 1'b1;
        if (frame_wrap) shadow <= vif.mode_str;
        stg[0] <= nxt_flags;
        for (int k = 1; k <= PIPE; k++) stg[k] <= stg[k-1];
      end
    end
  end

  // Stages hold while disabled; strobes are masked so each shows for one clk only
  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.hs          = stg[PIPE].hs;
  assign vif.vs          = stg[PIPE].vs;
  assign vif.de          = stg[PIPE].de;
  assign vif.border      = stg[PIPE].border;
  assign vif.blank       = stg[PIPE].blank;
  assign vif.line_start  = stg[PIPE].line_start & en_q;
  assign vif.frame_start = stg[PIPE].frame_start & en_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: PIPE=0 and PIPE=2 instances share stimulus and are checked
// against a raster-position reference model through an expected-value queue.
module tb_video_timing;

  localparam int W = 54;

  logic clk = 1'b0;
  logic reset_n;

  video_timing_if vif0();
  video_timing_if vif2();

  assign vif2.pix_en   = vif0.pix_en;
  assign vif2.mode_str = vif0.mode_str;

  video_timing #(.PIPE(0)) dut0 (.clk(clk), .reset_n(reset_n), .vif(vif0));
  video_timing #(.PIPE(2)) dut2 (.clk(clk), .reset_n(reset_n), .vif(vif2));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef logic [6:0] fl_t;  // {hs, vs, de, border, blank, line_start, frame_start}

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  int           m_h, m_v;
  bit           m_started;
  bit           m_en;
  logic [121:0] m_shadow;
  fl_t          hist[3];

  // idx: 0 act, 1 rb, 2 fp, 3 sy, 4 bp, 5 tot; base 61 = horizontal, 0 = vertical
  function automatic int fld(logic [121:0] m, int base, int idx);
    return int'(m[base + (5 - idx) * 10 +: 10]);
  endfunction

  function automatic bit inr(int c, int lo, int hi);
    return (c > lo) && (c <= hi);
  endfunction

  function automatic fl_t flags_at(logic [121:0] m, int h, int v);
    bit de, bl, hs, vs;
    de = (h <= fld(m, 61, 0)) && (v <= fld(m, 0, 0));
    bl = inr(h, fld(m, 61, 1), fld(m, 61, 4)) || inr(v, fld(m, 0, 1), fld(m, 0, 4));
    hs = inr(h, fld(m, 61, 2), fld(m, 61, 3)) ? m[121] : !m[121];
    vs = inr(v, fld(m, 0, 2), fld(m, 0, 3)) ? m[60] : !m[60];
    return {hs, vs, de, !de && !bl, bl, h == 0, (h == 0) && (v == 0)};
  endfunction

  task automatic model_edge(input logic rst_n_v, input logic en_v, input logic [121:0] m);
    fl_t o0, o2;
    if (!rst_n_v) begin
      m_h = 0; m_v = 0; m_started = 0; m_en = 0; m_shadow = m;
      for (int i = 0; i < 3; i++) hist[i] = {~m[121], ~m[60], 5'b0};
    end else begin
      m_en = en_v;
      if (en_v) begin
        if (!m_started) m_started = 1;
        else begin
          m_h++;
          if (m_h > fld(m_shadow, 61, 5)) begin
            m_h = 0;
            m_v++;
            if (m_v > fld(m_shadow, 0, 5)) begin
              m_v = 0;
              m_shadow = m;
            end
          end
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = flags_at(m_shadow, m_h, m_v);
      end
    end
    o0 = hist[0];
    o2 = hist[2];
    if (!m_en) begin
      o0[1:0] = 2'b00;
      o2[1:0] = 2'b00;
    end
    exp_q.push_back({10'(m_h), 10'(m_v), o0, o2, 10'(m_h), 10'(m_v)});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst_n_v, input logic en_v, input logic [121:0] m);
    @(negedge clk);
    reset_n       = rst_n_v;
    vif0.pix_en   = en_v;
    vif0.mode_str = m;
    @(posedge clk);
    model_edge(rst_n_v, en_v, m);
  endtask

  function automatic logic [60:0] mk(bit sp, int a, int r, int f, int s, int b, int t);
    return {sp, 10'(a), 10'(r), 10'(f), 10'(s), 10'(b), 10'(t)};
  endfunction

  function automatic logic [60:0] rnd_axis(int lo, int hi);
    int t, tmp;
    int v[5];
    t = int'($urandom_range(hi, lo));
    for (int i = 0; i < 5; i++) v[i] = int'($urandom_range(t, 0));
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    return mk(bit'($urandom_range(1, 0)), v[0], v[1], v[2], v[3], v[4], t);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {vif0.h_cnt, vif0.v_cnt,
               vif0.hs, vif0.vs, vif0.de, vif0.border, vif0.blank, vif0.line_start, vif0.frame_start,
               vif2.hs, vif2.vs, vif2.de, vif2.border, vif2.blank, vif2.line_start, vif2.frame_start,
               vif2.h_cnt, vif2.v_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL raster t=%0t got h=%0d v=%0d f0=%b f2=%b h2=%0d v2=%0d | need h=%0d v=%0d f0=%b f2=%b h2=%0d v2=%0d",
                 $time, act_v[53:44], act_v[43:34], act_v[33:27], act_v[26:20], act_v[19:10], act_v[9:0],
                 exp_v[53:44], exp_v[43:34], exp_v[33:27], exp_v[26:20], exp_v[19:10], exp_v[9:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [121:0] pal, mono, m;
    int           n;
    pal  = {mk(1, 639, 679, 759, 799, 951, 991), mk(1, 3, 4, 5, 6, 7, 8)};
    mono = {mk(0, 639, 639, 663, 703, 831, 831), mk(0, 2, 2, 3, 4, 5, 5)};

    reset_n       = 1'b0;
    vif0.pix_en   = 1'b0;
    vif0.mode_str = pal;

    repeat (3) step(1'b0, 1'b1, pal);

    // Full pal-like frame with a mid-frame switch to mono, then a mono frame
    for (int i = 0; i < 14000; i++) step(1'b1, 1'b1, (i < 4000) ? pal : mono);

    // Alternating enable
    for (int i = 0; i < 40; i++) step(1'b1, 1'(i % 2 == 0), mono);

    // Mid-frame reset and release
    for (int i = 0; i < 1500; i++) step(1'b1, 1'b1, pal);
    step(1'b0, 1'b1, pal);
    step(1'b1, 1'b1, pal);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, pal);

    // Randomised small modes, enables, mode changes and resets
    for (int seg = 0; seg < 40; seg++) begin
      m = {rnd_axis(1, 40), rnd_axis(0, 15)};
      if ($urandom_range(3, 0) == 0) begin
        step(1'b0, 1'($urandom_range(1, 0)), m);
        step(1'b1, 1'b1, m);
      end
      n = int'($urandom_range(600, 50));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(99, 0) < 2) m = {rnd_axis(1, 40), rnd_axis(0, 15)};
        step(1'b1, 1'($urandom_range(3, 0) != 0), m);
      end
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending need 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
